// File: rtl/stim.sv
// Stimulus sequencer: walks 4-word test records in memory, drives the DUT, captures its
// response and pushes RES_FIFO / CHECK_FIFO as an aligned pair; forwards bitmask records to the checker.
module stim #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16,
    parameter int RTF_WIDTH  = 24,
    parameter int CHF_WIDTH  = RTF_WIDTH + ADDR_WIDTH,
    parameter int SCC_WIDTH  = 5,
    parameter int SCD_WIDTH  = 24,
    parameter int RES_WORDS  = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_address,
    input  logic [ADDR_WIDTH-1:0] result_base,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_read,
    input  logic [DATA_WIDTH-1:0] mem_readdata,
    input  logic                  mem_waitrequest,
    output logic [RTF_WIDTH-1:0]  dut_in,
    input  logic [RTF_WIDTH-1:0]  dut_out,
    output logic [RTF_WIDTH-1:0]  rfifo_data,
    output logic                  rfifo_wrreq,
    input  logic                  rfifo_wrfull,
    output logic [CHF_WIDTH-1:0]  cfifo_data,
    output logic                  cfifo_wrreq,
    input  logic                  cfifo_wrfull,
    output logic [SCC_WIDTH-1:0]  sc_cmd,
    output logic [SCD_WIDTH-1:0]  sc_data,
    input  logic                  sc_ready
);

    localparam logic [SCC_WIDTH-1:0] SC_IDLE    = '0;
    localparam logic [SCC_WIDTH-1:0] SC_BITMASK = SCC_WIDTH'(1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MASK_WAIT,
        S_MASK_ISSUE,
        S_APPLY,
        S_SETTLE,
        S_CAPTURE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH-1:0] res_addr;
    logic [1:0]            word_cnt;
    logic [7:0]            settle_cnt;
    logic [RTF_WIDTH-1:0]  dut_in_r;

    logic                  rec_valid;
    logic                  rec_is_mask;
    logic [7:0]            rec_in_hi;
    logic [15:0]           rec_in_lo;
    logic [7:0]            rec_exp_hi;
    logic [15:0]           rec_exp_lo;
    logic [7:0]            rec_settle;
    logic [RTF_WIDTH-1:0]  rec_in;
    logic [RTF_WIDTH-1:0]  rec_exp;

    logic                  word_accept;
    logic                  push_ok;
    logic                  unused_meta;

    assign rec_in      = {rec_in_hi, rec_in_lo};
    assign rec_exp     = {rec_exp_hi, rec_exp_lo};
    assign word_accept = (state == S_FETCH) && !mem_waitrequest;
    assign push_ok     = (state == S_CAPTURE) && !rfifo_wrfull && !cfifo_wrfull;
    // meta[6:1] are reserved and carry no meaning
    assign unused_meta = ^mem_readdata[14:9];

    assign mem_address = rd_addr;
    assign dut_in      = dut_in_r;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        busy        = (state != S_IDLE);
        done        = 1'b0;
        mem_read    = 1'b0;
        rfifo_wrreq = 1'b0;
        cfifo_wrreq = 1'b0;
        rfifo_data  = '0;
        cfifo_data  = '0;
        sc_cmd      = SC_IDLE;
        sc_data     = '0;
        unique case (state)
            S_IDLE: begin
                if (start) state_nx = S_FETCH;
            end
            S_FETCH: begin
                mem_read = 1'b1;
                if (word_accept && word_cnt == 2'd3) state_nx = S_DECODE;
            end
            S_DECODE: begin
                if (!rec_valid)      state_nx = S_DRAIN;
                else if (rec_is_mask) state_nx = S_MASK_WAIT;
                else                 state_nx = S_APPLY;
            end
            // hold the mask back until nothing is in flight in the checker
            S_MASK_WAIT: begin
                if (sc_ready) state_nx = S_MASK_ISSUE;
            end
            S_MASK_ISSUE: begin
                sc_cmd   = SC_BITMASK;
                sc_data  = SCD_WIDTH'(rec_in);
                state_nx = S_FETCH;
            end
            S_APPLY: begin
                state_nx = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_cnt == 8'd0) state_nx = S_CAPTURE;
            end
            // both FIFOs are pushed together or not at all
            S_CAPTURE: begin
                if (push_ok) begin
                    rfifo_wrreq = 1'b1;
                    cfifo_wrreq = 1'b1;
                    rfifo_data  = dut_out;
                    cfifo_data  = {rec_exp, res_addr};
                    state_nx    = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (sc_ready) state_nx = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_addr    <= '0;
            res_addr   <= '0;
            word_cnt   <= '0;
            settle_cnt <= '0;
            dut_in_r   <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                rd_addr  <= base_address;
                res_addr <= result_base;
                word_cnt <= '0;
            end
            if (word_accept) begin
                rd_addr  <= rd_addr + ADDR_WIDTH'(1);
                word_cnt <= word_cnt + 2'd1;
            end
            if (state == S_APPLY) begin
                dut_in_r   <= rec_in;
                settle_cnt <= rec_settle;
            end else if (state == S_SETTLE && settle_cnt != 8'd0) begin
                settle_cnt <= settle_cnt - 8'd1;
            end
            if (push_ok) res_addr <= res_addr + ADDR_WIDTH'(RES_WORDS);
        end
    end

    // record fields are pure data and only read after all four words have landed
    always_ff @(posedge clock) begin
        if (word_accept) begin
            case (word_cnt)
                2'd0: begin
                    rec_valid   <= mem_readdata[15];
                    rec_is_mask <= mem_readdata[8];
                    rec_in_hi   <= mem_readdata[7:0];
                end
                2'd1: rec_in_lo <= mem_readdata[15:0];
                2'd2: begin
                    rec_exp_hi <= mem_readdata[15:8];
                    rec_settle <= mem_readdata[7:0];
                end
                default: rec_exp_lo <= mem_readdata[15:0];
            endcase
        end
    end

endmodule

// File: tb/tb_stim.sv
// Bench for stim: memory, loopback DUT and FIFO/checker handshakes around a record-level
// reference model that predicts reads, pushes, mask commands and done timing cycle by cycle.
`timescale 1ns/1ps
module tb_stim;

    localparam int AW = 20;
    localparam int RW = 24;
    localparam int CW = RW + AW;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_address = '0;
    logic [AW-1:0] result_base = '0;
    logic          busy, done, mem_read;
    logic [AW-1:0] mem_address;
    logic [15:0]   mem_readdata;
    logic          mem_waitrequest = 1'b0;
    logic [RW-1:0] dut_in, dut_out, rfifo_data;
    logic          rfifo_wrreq;
    logic          rfifo_wrfull = 1'b0;
    logic [CW-1:0] cfifo_data;
    logic          cfifo_wrreq;
    logic          cfifo_wrfull = 1'b0;
    logic [4:0]    sc_cmd;
    logic [23:0]   sc_data;
    logic          sc_ready = 1'b1;

    logic [15:0]   mem [64];

    assign mem_readdata = mem[mem_address[5:0]];
    assign dut_out      = dut_in;

    stim dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .base_address(base_address), .result_base(result_base),
        .busy(busy), .done(done),
        .mem_address(mem_address), .mem_read(mem_read),
        .mem_readdata(mem_readdata), .mem_waitrequest(mem_waitrequest),
        .dut_in(dut_in), .dut_out(dut_out),
        .rfifo_data(rfifo_data), .rfifo_wrreq(rfifo_wrreq), .rfifo_wrfull(rfifo_wrfull),
        .cfifo_data(cfifo_data), .cfifo_wrreq(cfifo_wrreq), .cfifo_wrfull(cfifo_wrfull),
        .sc_cmd(sc_cmd), .sc_data(sc_data), .sc_ready(sc_ready)
    );

    initial forever #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // reference model state: one record in flight at a time
    bit            m_on = 1'b0;
    bit            m_fin = 1'b0;
    int            m_kind = 0;      // 0 fetching, 1 vector, 2 mask, 3 end, 4 finished
    int            m_fetch_from = 0;
    int            m_busy_from = 0;
    int            m_earliest = 0;
    int            m_wait_from = 0;
    int            m_fire_at = -1;
    int            m_nread = 0;
    int            m_nvec = 0;
    logic [AW-1:0] m_base = '0;
    logic [AW-1:0] m_rbase = '0;
    logic [23:0]   m_vin = '0, m_vexp = '0, m_mask = '0;

    int            n_push = 0, n_done_obs = 0, n_mask = 0, n_reads = 0, n_stall = 0;
    int            mask_cyc = 0, chg_cyc = 0;
    logic [23:0]   mask_val = '0;
    logic [CW-1:0] log_cf [16];
    logic [RW-1:0] log_rd [16];
    int            log_gap [16];
    logic [AW-1:0] log_ra [32];

    bit            prev_stall = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [23:0]   last_din = '0;
    logic          exp_rd, exp_push, exp_done, exp_busy;
    logic [4:0]    exp_cmd;
    logic [AW-1:0] ea, r0;
    logic [5:0]    ix;
    logic [15:0]   w0, w1, w2, w3;

    initial forever begin
        @(negedge clock);
        if (dut_in !== last_din) begin
            chg_cyc  = cyc;
            last_din = dut_in;
        end
        if (m_on && reset_n) begin
            exp_rd = (m_kind == 0) && (cyc >= m_fetch_from) && !m_fin;
            chk("mem_read", 64'(mem_read), 64'(exp_rd));
            if (prev_stall) chk("stall_addr_hold", 64'(mem_address), 64'(prev_addr));
            prev_stall = mem_read && mem_waitrequest;
            prev_addr  = mem_address;
            if (mem_read && mem_waitrequest) n_stall++;
            if (mem_read && !mem_waitrequest) begin
                ea = m_base + AW'(m_nread);
                chk("mem_address", 64'(mem_address), 64'(ea));
                log_ra[n_reads % 32] = mem_address;
                n_reads++;
                m_nread++;
                if (m_nread % 4 == 0) begin
                    r0 = m_base + AW'(m_nread - 4);
                    ix = r0[5:0];
                    w0 = mem[ix];
                    w1 = mem[ix + 6'd1];
                    w2 = mem[ix + 6'd2];
                    w3 = mem[ix + 6'd3];
                    m_fire_at = -1;
                    if (!w0[15]) begin
                        m_kind = 3;
                        m_wait_from = cyc + 2;
                    end else if (w0[8]) begin
                        m_kind = 2;
                        m_mask = {w0[7:0], w1};
                        m_wait_from = cyc + 2;
                    end else begin
                        m_kind = 1;
                        m_vin = {w0[7:0], w1};
                        m_vexp = {w2[15:8], w3};
                        m_earliest = cyc + 4 + int'(w2[7:0]);
                    end
                end
            end

            exp_push = (m_kind == 1) && (cyc >= m_earliest) && !rfifo_wrfull && !cfifo_wrfull;
            chk("rfifo_wrreq", 64'(rfifo_wrreq), 64'(exp_push));
            chk("cfifo_wrreq", 64'(cfifo_wrreq), 64'(exp_push));
            if (exp_push && rfifo_wrreq) begin
                ea = m_rbase + AW'(2 * m_nvec);
                chk("rfifo_data", 64'(rfifo_data), 64'(m_vin));
                chk("cfifo_data", 64'(cfifo_data), 64'({m_vexp, ea}));
                log_cf[n_push % 16]  = cfifo_data;
                log_rd[n_push % 16]  = rfifo_data;
                log_gap[n_push % 16] = cyc - chg_cyc;
                n_push++;
                m_nvec++;
                m_kind = 0;
                m_fetch_from = cyc + 1;
            end

            exp_cmd = (m_kind == 2 && cyc == m_fire_at) ? 5'd1 : 5'd0;
            chk("sc_cmd", 64'(sc_cmd), 64'(exp_cmd));
            exp_busy = !m_fin && (cyc >= m_busy_from);
            chk("busy", 64'(busy), 64'(exp_busy));
            exp_done = (m_kind == 3) && (cyc == m_fire_at);
            chk("done", 64'(done), 64'(exp_done));
            if (done) n_done_obs++;
            if (exp_cmd == 5'd1) begin
                chk("sc_data", 64'(sc_data), 64'(m_mask));
                n_mask++;
                mask_cyc = cyc;
                mask_val = sc_data;
                m_kind = 0;
                m_fetch_from = cyc + 1;
                m_fire_at = -1;
            end else if (exp_done) begin
                m_kind = 4;
                m_fin = 1'b1;
            end else if ((m_kind == 2 || m_kind == 3) && m_fire_at < 0 &&
                         cyc >= m_wait_from && sc_ready) begin
                m_fire_at = cyc + 1;
            end
        end
    end

    bit rnd_en = 1'b0;
    initial forever begin
        @(posedge clock);
        #1;
        if (rnd_en) begin
            mem_waitrequest = ($urandom % 3) == 0;
            rfifo_wrfull    = ($urandom % 4) == 0;
            cfifo_wrfull    = ($urandom % 5) == 0;
            sc_ready        = ($urandom % 3) != 0;
        end
    end

    task automatic put_rec(input logic [AW-1:0] a, input logic [7:0] meta,
                           input logic [23:0] vin, input logic [23:0] vexp, input logic [7:0] st);
        logic [5:0] p;
        p = a[5:0];
        mem[p]        = {meta, vin[23:16]};
        mem[p + 6'd1] = vin[15:0];
        mem[p + 6'd2] = {vexp[23:16], st};
        mem[p + 6'd3] = vexp[15:0];
    endtask

    task automatic run_start(input logic [AW-1:0] b, input logic [AW-1:0] rb);
        @(posedge clock);
        #1;
        base_address = b;
        result_base  = rb;
        start        = 1'b1;
        m_base = b; m_rbase = rb; m_kind = 0; m_fin = 1'b0; m_fire_at = -1;
        m_nread = 0; m_nvec = 0; m_fetch_from = cyc + 1; m_busy_from = cyc + 1;
        n_push = 0; n_done_obs = 0; n_mask = 0; n_reads = 0; n_stall = 0;
        prev_stall = 1'b0;
        m_on = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int k;
        k = 0;
        while (!m_fin && k < limit) begin
            @(negedge clock);
            k++;
        end
        chk("run_completes", 64'(m_fin), 64'(1));
        repeat (3) @(negedge clock);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_mem_read"}, 64'(mem_read), 64'(0));
        chk({tag, "_mem_address"}, 64'(mem_address), 64'(0));
        chk({tag, "_dut_in"}, 64'(dut_in), 64'(0));
        chk({tag, "_rfifo_wrreq"}, 64'(rfifo_wrreq), 64'(0));
        chk({tag, "_rfifo_data"}, 64'(rfifo_data), 64'(0));
        chk({tag, "_cfifo_wrreq"}, 64'(cfifo_wrreq), 64'(0));
        chk({tag, "_cfifo_data"}, 64'(cfifo_data), 64'(0));
        chk({tag, "_sc_cmd"}, 64'(sc_cmd), 64'(0));
        chk({tag, "_sc_data"}, 64'(sc_data), 64'(0));
    endtask

    task automatic rnd_run(input int r);
        logic [AW-1:0] b, a, rb;
        int            nr, nv;
        logic [7:0]    meta;
        b  = AW'($urandom);
        rb = AW'($urandom);
        nr = 1 + int'($urandom % 6);
        nv = 0;
        a  = b;
        for (int i = 0; i < nr; i++) begin
            if ($urandom % 4 == 0) begin
                meta = 8'h81 | (8'($urandom) & 8'h7E);
            end else begin
                meta = 8'h80 | (8'($urandom) & 8'h7E);
                nv++;
            end
            put_rec(a, meta, 24'($urandom), 24'($urandom), 8'($urandom % 7));
            a = a + AW'(4);
        end
        put_rec(a, 8'($urandom) & 8'h7F, 24'($urandom), 24'($urandom), 8'($urandom));
        run_start(b, rb);
        // a second start while busy must not disturb the run
        repeat (2) @(posedge clock);
        #1;
        base_address = ~b;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_done(5000);
        chk($sformatf("rnd%0d_pushes", r), 64'(n_push), 64'(nv));
    endtask

    initial begin
        int k, rel;
        logic [23:0] old_din;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        put_rec(20'h00010, 8'h80, 24'h000001, 24'h000001, 8'd2);
        put_rec(20'h00014, 8'h80, 24'h000002, 24'h000002, 8'd2);
        put_rec(20'h00018, 8'h80, 24'h000003, 24'h000003, 8'd2);
        put_rec(20'h0001C, 8'h00, 24'h0, 24'h0, 8'd0);
        put_rec(20'h00020, 8'h81, 24'h00FF00, 24'h0, 8'd0);
        put_rec(20'h00024, 8'h80, 24'h123456, 24'h654321, 8'd1);
        put_rec(20'h00028, 8'h00, 24'h0, 24'h0, 8'd0);
        put_rec(20'h0002C, 8'h80, 24'h0000A1, 24'h0A0A0A, 8'd0);
        put_rec(20'h00030, 8'h80, 24'h0000B2, 24'h0B0B0B, 8'd5);
        put_rec(20'h00034, 8'h80, 24'h0000C3, 24'h0C0C0C, 8'd0);
        put_rec(20'h00038, 8'h00, 24'h0, 24'h0, 8'd0);
        put_rec(20'hFFFFE, 8'h80, 24'hABCDEF, 24'hFEDCBA, 8'd3);
        put_rec(20'h00002, 8'h00, 24'h0, 24'h0, 8'd0);

        repeat (3) @(posedge clock);
        #2;
        chk_zero("reset");
        @(negedge clock);
        reset_n = 1'b1;

        // three loopback vectors, settle 2
        run_start(20'h00010, 20'h00100);
        wait_done(300);
        chk("A_push_count", 64'(n_push), 64'(3));
        chk("A_cf0", 64'(log_cf[0]), 64'({24'h000001, 20'h00100}));
        chk("A_cf1_addr", 64'(log_cf[1][19:0]), 64'(20'h00102));
        chk("A_cf2_addr", 64'(log_cf[2][19:0]), 64'(20'h00104));
        chk("A_rd2", 64'(log_rd[2]), 64'(24'h000003));
        chk("A_done_pulses", 64'(n_done_obs), 64'(1));
        chk("A_dut_in_hold", 64'(dut_in), 64'(24'h000003));

        // waitrequest held 5 cycles on the second record word
        run_start(20'h00010, 20'h00200);
        k = 0;
        while (!(mem_read && mem_address == 20'h00011) && k < 50) begin
            @(posedge clock);
            #1;
            k++;
        end
        chk("B_reached_w1", 64'(mem_address), 64'(20'h00011));
        mem_waitrequest = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        mem_waitrequest = 1'b0;
        wait_done(300);
        chk("B_stall_cycles", 64'(n_stall), 64'(5));
        chk("B_rd0", 64'(log_rd[0]), 64'(24'h000001));
        chk("B_cf2", 64'(log_cf[2]), 64'({24'h000003, 20'h00204}));

        // bitmask held back by sc_ready
        sc_ready = 1'b0;
        run_start(20'h00020, 20'h00300);
        repeat (20) @(posedge clock);
        #1;
        sc_ready = 1'b1;
        rel = cyc;
        wait_done(300);
        chk("C_mask_count", 64'(n_mask), 64'(1));
        chk("C_mask_value", 64'(mask_val), 64'(24'h00FF00));
        chk("C_mask_timing", 64'(mask_cyc), 64'(rel + 1));
        chk("C_cf0", 64'(log_cf[0]), 64'({24'h654321, 20'h00300}));

        // settle 0 under rfifo_wrfull, settle 5, settle 0
        run_start(20'h0002C, 20'h00400);
        old_din = dut_in;
        k = 0;
        while (dut_in == old_din && k < 50) begin
            @(posedge clock);
            #1;
            k++;
        end
        chk("D_first_apply", 64'(dut_in), 64'(24'h0000A1));
        rfifo_wrfull = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        rfifo_wrfull = 1'b0;
        wait_done(300);
        chk("D_gap_full", 64'(log_gap[0]), 64'(5));
        chk("D_gap_settle5", 64'(log_gap[1]), 64'(6));
        chk("D_gap_settle0", 64'(log_gap[2]), 64'(1));
        chk("D_push_count", 64'(n_push), 64'(3));

        // address wrap on both pointers
        run_start(20'hFFFFE, 20'hFFFFF);
        wait_done(300);
        chk("E_ra1", 64'(log_ra[1]), 64'(20'hFFFFF));
        chk("E_ra2", 64'(log_ra[2]), 64'(20'h00000));
        chk("E_cf0", 64'(log_cf[0]), 64'({24'hFEDCBA, 20'hFFFFF}));
        chk("E_reads", 64'(n_reads), 64'(8));

        // asynchronous reset in the middle of a fetch
        mem_waitrequest = 1'b1;
        run_start(20'h00020, 20'h00500);
        @(posedge clock);
        #3;
        chk("F_busy_before", 64'(busy), 64'(1));
        m_on = 1'b0;
        reset_n = 1'b0;
        #1;
        chk_zero("midrst");
        mem_waitrequest = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        chk("F_idle_after", 64'(busy), 64'(0));
        run_start(20'h00020, 20'h00500);
        wait_done(300);
        chk("F_mask_count", 64'(n_mask), 64'(1));
        chk("F_cf0", 64'(log_cf[0]), 64'({24'h654321, 20'h00500}));

        // randomized records and handshakes
        rnd_en = 1'b1;
        for (int r = 0; r < 6; r++) rnd_run(r);
        rnd_en = 1'b0;
        @(posedge clock);
        #1;
        mem_waitrequest = 1'b0;
        rfifo_wrfull = 1'b0;
        cfifo_wrfull = 1'b0;
        sc_ready = 1'b1;
        repeat (2) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
